// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: issues PC reads, holds the returned word
// for decode, and handles redirect, halt/resume and memory timeout.
module fetch_controller #(
    parameter logic [27:0] RESET_VECTOR = 28'h0000000,
    parameter int          MEM_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        resume,
    input  logic        halt_req,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        instr_accept,
    input  logic        branch_taken,
    input  logic [27:0] branch_target,
    output logic        fetch,
    output logic        incpc,
    output logic [27:0] pcout,
    output logic        mem_req,
    output logic [27:0] mem_addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH   = 3'd1;
    localparam logic [2:0] DELIVER = 3'd2;
    localparam logic [2:0] HALT    = 3'd3;
    localparam logic [2:0] ERROR   = 3'd4;

    localparam int          CW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [27:0]   pc;
    logic [31:0]   word;

    logic fetching;
    logic delivering;
    logic take;
    logic expire;
    logic consume;

    assign fetching   = (state == FETCH);
    assign delivering = (state == DELIVER);
    assign take       = fetching && mem_ready;
    assign expire     = fetching && !mem_ready && (wait_cnt == LIMIT);
    assign consume    = delivering && instr_accept;

    assign fetch       = fetching;
    assign mem_req     = fetching;
    assign mem_addr    = fetching ? pc : 28'h0000000;
    assign incpc       = take;
    assign pcout       = pc;
    assign instr       = word;
    assign instr_valid = delivering;
    assign err         = (state == ERROR);

    // Next-state selection; undefined encodings fall back to IDLE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                state_nxt = run ? FETCH : IDLE;
            end
            FETCH: begin
                if (take) begin
                    state_nxt = DELIVER;
                end else if (expire) begin
                    state_nxt = ERROR;
                end else begin
                    state_nxt = FETCH;
                end
            end
            DELIVER: begin
                if (!instr_accept) begin
                    state_nxt = DELIVER;
                end else if (halt_req) begin
                    state_nxt = HALT;
                end else if (run) begin
                    state_nxt = FETCH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HALT: begin
                state_nxt = resume ? FETCH : HALT;
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory-wait counter: runs only while a request is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (fetching && !mem_ready && !expire) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // PC: advances on capture (wrapping at 28 bits), redirects on taken branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VECTOR;
        end else if (take) begin
            pc <= pc + 28'd1;
        end else if (consume && branch_taken) begin
            pc <= branch_target;
        end
    end

    // Instruction holding register, loaded when memory answers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= 32'h0;
        end else if (take) begin
            word <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: vector table, directed corner sequences,
// and randomized traffic against an abstract reference model.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        resume = 1'b0;
    logic        halt_req = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        instr_accept = 1'b0;
    logic        branch_taken = 1'b0;
    logic [27:0] branch_target = 28'h0;
    logic        fetch;
    logic        incpc;
    logic [27:0] pcout;
    logic        mem_req;
    logic [27:0] mem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        err;

    fetch_controller #(
        .RESET_VECTOR(28'h0000000),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .resume       (resume),
        .halt_req     (halt_req),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .instr_accept (instr_accept),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .fetch        (fetch),
        .incpc        (incpc),
        .pcout        (pcout),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [92:0] obs;
    assign obs = {fetch, incpc, mem_req, mem_addr, pcout, instr_valid, instr, err};

    typedef struct {
        logic        run;
        logic        res;
        logic        halt;
        logic        rdy;
        logic [31:0] rdata;
        logic        acc;
        logic        br;
        logic [27:0] tgt;
        logic [92:0] exp;
    } vec_t;

    vec_t tab[20];

    function automatic logic [92:0] ex(input logic f, input logic inc,
                                       input logic req, input logic [27:0] a,
                                       input logic [27:0] p, input logic v,
                                       input logic [31:0] w, input logic e);
        return {f, inc, req, a, p, v, w, e};
    endfunction

    function automatic vec_t mv(input logic r, input logic s, input logic h,
                                input logic y, input logic [31:0] d,
                                input logic a, input logic b,
                                input logic [27:0] t, input logic [92:0] e);
        vec_t v;
        v.run = r; v.res = s; v.halt = h; v.rdy = y; v.rdata = d;
        v.acc = a; v.br = b; v.tgt = t; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [92:0] act,
                       input logic [92:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic put(input logic r, input logic s, input logic h,
                       input logic y, input logic [31:0] d, input logic a,
                       input logic b, input logic [27:0] t);
        run = r; resume = s; halt_req = h; mem_ready = y;
        mem_rdata = d; instr_accept = a; branch_taken = b; branch_target = t;
    endtask

    task automatic do_reset();
        @(negedge clk);
        put(0, 0, 0, 0, 32'h0, 0, 0, 28'h0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Abstract model state.
    bit          m_busy, m_hold, m_park, m_dead;
    int          m_wait;
    logic [27:0] m_pc;
    logic [31:0] m_word;

    task automatic model_reset();
        m_busy = 0; m_hold = 0; m_park = 0; m_dead = 0;
        m_wait = 0; m_pc = 28'h0; m_word = 32'h0;
    endtask

    task automatic model_step();
        if (m_busy) begin
            if (mem_ready) begin
                m_word = mem_rdata;
                m_pc = 28'((64'(m_pc) + 1) % (64'd1 << 28));
                m_busy = 0; m_hold = 1; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == 16) begin
                    m_busy = 0; m_dead = 1;
                end
            end
        end else if (m_hold) begin
            if (instr_accept) begin
                if (branch_taken) m_pc = branch_target;
                m_hold = 0;
                if (halt_req) m_park = 1;
                else if (run) m_busy = 1;
            end
        end else if (m_park) begin
            if (resume) begin
                m_park = 0; m_busy = 1;
            end
        end else if (!m_dead && run) begin
            m_busy = 1;
        end
    endtask

    initial begin
        int reqs;
        int dead_cycles;
        logic [92:0] e;

        tab[0]  = mv(0,0,0,0,32'h0,0,0,28'h0, ex(0,0,0,28'h0,28'h0,0,32'h0,0));
        tab[1]  = mv(1,0,0,0,32'h0,0,0,28'h0, ex(0,0,0,28'h0,28'h0,0,32'h0,0));
        tab[2]  = mv(1,0,0,0,32'h0,0,0,28'h0, ex(1,0,1,28'h0,28'h0,0,32'h0,0));
        tab[3]  = mv(1,0,0,0,32'h0,0,0,28'h0, ex(1,0,1,28'h0,28'h0,0,32'h0,0));
        tab[4]  = mv(1,0,0,1,32'hA5A50001,0,0,28'h0,
                     ex(1,1,1,28'h0,28'h0,0,32'h0,0));
        tab[5]  = mv(1,0,0,0,32'h0,1,0,28'h0,
                     ex(0,0,0,28'h0,28'h1,1,32'hA5A50001,0));
        tab[6]  = mv(1,0,0,0,32'h0,0,0,28'h0,
                     ex(1,0,1,28'h1,28'h1,0,32'hA5A50001,0));
        tab[7]  = mv(1,0,0,1,32'h11,0,0,28'h0,
                     ex(1,1,1,28'h1,28'h1,0,32'hA5A50001,0));
        tab[8]  = mv(1,0,1,0,32'h0,0,1,28'h99,
                     ex(0,0,0,28'h0,28'h2,1,32'h11,0));
        tab[9]  = mv(1,0,0,0,32'h0,1,1,28'h40,
                     ex(0,0,0,28'h0,28'h2,1,32'h11,0));
        tab[10] = mv(1,0,0,0,32'h0,0,0,28'h0,
                     ex(1,0,1,28'h40,28'h40,0,32'h11,0));
        tab[11] = mv(1,0,0,1,32'h22,0,0,28'h0,
                     ex(1,1,1,28'h40,28'h40,0,32'h11,0));
        tab[12] = mv(1,0,1,0,32'h0,1,0,28'h0,
                     ex(0,0,0,28'h0,28'h41,1,32'h22,0));
        tab[13] = mv(1,0,0,1,32'h0,1,1,28'h7,
                     ex(0,0,0,28'h0,28'h41,0,32'h22,0));
        tab[14] = mv(1,1,0,0,32'h0,0,0,28'h0,
                     ex(0,0,0,28'h0,28'h41,0,32'h22,0));
        tab[15] = mv(0,0,0,0,32'h0,0,0,28'h0,
                     ex(1,0,1,28'h41,28'h41,0,32'h22,0));
        tab[16] = mv(0,0,0,1,32'h33,0,0,28'h0,
                     ex(1,1,1,28'h41,28'h41,0,32'h22,0));
        tab[17] = mv(0,0,0,0,32'h0,1,0,28'h0,
                     ex(0,0,0,28'h0,28'h42,1,32'h33,0));
        tab[18] = mv(0,0,0,0,32'h0,0,0,28'h0,
                     ex(0,0,0,28'h0,28'h42,0,32'h33,0));
        tab[19] = mv(1,0,0,0,32'h0,0,0,28'h0,
                     ex(0,0,0,28'h0,28'h42,0,32'h33,0));

        // Reset state, checked while reset is held.
        #2;
        chk("reset_hold", obs, ex(0,0,0,28'h0,28'h0,0,32'h0,0));

        // Vector table.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            put(tab[i].run, tab[i].res, tab[i].halt, tab[i].rdy,
                tab[i].rdata, tab[i].acc, tab[i].br, tab[i].tgt);
            #1;
            chk($sformatf("vec%0d", i), obs, tab[i].exp);
            @(negedge clk);
        end

        // PC wrap at the top of the 28-bit space.
        do_reset();
        put(1,0,0,0,32'h0,0,0,28'h0);
        @(negedge clk);
        put(1,0,0,1,32'h5,0,0,28'h0);
        @(negedge clk);
        put(1,0,0,0,32'h0,1,1,28'hFFFFFFF);
        @(negedge clk);
        put(1,0,0,1,32'h6,0,0,28'h0);
        #1;
        chk("wrap_inc", 93'({incpc, mem_addr}), 93'({1'b1, 28'hFFFFFFF}));
        @(negedge clk);
        put(0,0,0,0,32'h0,0,0,28'h0);
        #1;
        chk("wrap_pc", 93'({incpc, pcout, instr_valid, instr}),
            93'({1'b0, 28'h0, 1'b1, 32'h6}));

        // Memory timeout into a sticky error.
        do_reset();
        put(1,0,0,0,32'h0,0,0,28'h0);
        @(negedge clk);
        repeat (15) begin
            put(1,0,0,0,32'h0,0,0,28'h0);
            @(negedge clk);
        end
        #1;
        chk("to_edge", 93'({mem_req, err}), 93'({1'b1, 1'b0}));
        @(negedge clk);
        #1;
        chk("to_err", 93'({mem_req, fetch, err}), 93'({1'b0, 1'b0, 1'b1}));
        repeat (5) begin
            put(1,1,1,1,32'h1,1,1,28'h5);
            @(negedge clk);
        end
        #1;
        chk("err_sticky", 93'({err, mem_req, pcout}), 93'({1'b1, 1'b0, 28'h0}));
        rst_n = 1'b0;
        #1;
        chk("err_rst", 93'({err, mem_req}), 93'(0));

        // Memory answering on the limit cycle wins over the timeout.
        do_reset();
        put(1,0,0,0,32'h0,0,0,28'h0);
        @(negedge clk);
        repeat (15) begin
            put(1,0,0,0,32'h0,0,0,28'h0);
            @(negedge clk);
        end
        put(1,0,0,1,32'hBEEF,0,0,28'h0);
        #1;
        chk("limit_inc", 93'(incpc), 93'(1));
        @(negedge clk);
        #1;
        chk("limit_cap", 93'({instr_valid, instr, err}),
            93'({1'b1, 32'hBEEF, 1'b0}));

        // Halt holds off fetching until resume.
        do_reset();
        put(1,0,0,0,32'h0,0,0,28'h0);
        @(negedge clk);
        put(1,0,0,1,32'h7,0,0,28'h0);
        @(negedge clk);
        put(1,0,1,0,32'h0,1,0,28'h0);
        @(negedge clk);
        reqs = 0;
        repeat (10) begin
            put(1,0,0,1,32'h0,0,0,28'h0);
            #1;
            reqs += int'(mem_req);
            @(negedge clk);
        end
        chk("halt_quiet", 93'(reqs), 93'(0));
        put(1,1,0,0,32'h0,0,0,28'h0);
        #1;
        chk("halt_resume_cyc", 93'(mem_req), 93'(0));
        @(negedge clk);
        put(1,0,0,0,32'h0,0,0,28'h0);
        #1;
        chk("resume_fetch", 93'({mem_req, mem_addr}), 93'({1'b1, 28'h1}));

        // Reset in the middle of an outstanding fetch.
        do_reset();
        put(1,0,0,0,32'h0,0,0,28'h0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_midfetch", 93'({mem_req, fetch, pcout}), 93'(0));
        put(0,0,0,1,32'hDEADBEEF,0,0,28'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        put(0,0,0,0,32'h0,0,0,28'h0);
        #1;
        chk("rst_ignore", 93'({instr, instr_valid, pcout, mem_req}), 93'(0));

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        dead_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            put($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0, 28'($urandom));
            #1;
            e = ex(m_busy, m_busy && mem_ready, m_busy,
                   m_busy ? m_pc : 28'h0, m_pc, m_hold, m_word, m_dead);
            chk($sformatf("rand%0d", n), obs, e);
            model_step();
            if (m_dead) dead_cycles++;
            if (dead_cycles > 4) begin
                do_reset();
                model_reset();
                dead_cycles = 0;
            end else begin
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
